// File: rtl/m_instruction_encoder.sv
// m_instruction_encoder: two-stage RV32I field-to-word encoder with valid/ready, optional IMM_CHECK_EN range flag
module m_instruction_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode5,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [5:0]       out_fmt,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);
  logic        s1_valid, s2_valid, s1_adv, s2_adv;
  logic [4:0]  s1_op, s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm, inst;
  logic [5:0]  s1_fmt, fmt;
  logic [6:0]  opc;
  logic        err;
  assign out_valid = s2_valid;
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s2_adv;
    fmt[5]   = opcode5 == 5'b01100;
    fmt[3]   = opcode5 == 5'b01000;
    fmt[2]   = opcode5 == 5'b11000;
    fmt[1]   = opcode5 == 5'b01101 || opcode5 == 5'b00101;
    fmt[0]   = opcode5 == 5'b11011;
    fmt[4]   = ~|{fmt[5], fmt[3:0]};
    opc      = {s1_op, 2'b11};
    inst     = s1_fmt[5] ? {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, opc} :
               s1_fmt[3] ? {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], opc} :
               s1_fmt[2] ? {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], opc} :
               s1_fmt[1] ? {s1_imm[31:12], s1_rd, opc} :
               s1_fmt[0] ? {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, opc} :
                           {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, opc};
`ifdef IMM_CHECK_EN
    err      = (s1_fmt[4] || s1_fmt[3]) ? s1_imm[31:11] != {21{s1_imm[11]}} :
               s1_fmt[2] ? (s1_imm[31:12] != {20{s1_imm[12]}}) || s1_imm[0] :
               s1_fmt[0] ? (s1_imm[31:20] != {12{s1_imm[20]}}) || s1_imm[0] :
               s1_fmt[1] ? |s1_imm[11:0] : 1'b0;
`else
    err      = 1'b0;
`endif
  end
`ifndef IMM_CHECK_EN
  logic unused_imm0;
  assign unused_imm0 = s1_imm[0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_inst  <= '0;
      out_fmt   <= '0;
      out_err   <= 1'b0;
      out_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= opcode5;
          s1_rd  <= rd;
          s1_rs1 <= rs1;
          s1_rs2 <= rs2;
          s1_f3  <= funct3;
          s1_f7  <= funct7;
          s1_imm <= imm;
          s1_fmt <= fmt;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_adv) begin
          out_inst <= inst;
          out_fmt  <= s1_fmt;
          out_err  <= err;
        end
      end
      if (s2_valid && out_ready) out_count <= out_count + 1'b1;
    end
  end
endmodule

// File: doc/m_instruction_encoder.md
Name: m_instruction_encoder

Overview:
Instruction encoder: packs opcode5, register fields, funct fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Format is derived from opcode5 with the same rules as m_instruction_type, so encoder and decoder agree by construction.
- Two-stage valid/ready pipeline with full throughput and backpressure, plus an emitted-instruction counter.
- Sits between the test-program generator / assembler front end and instruction memory write logic.

Parameters:
CNT_W, 16, width of out_count (emitted-instruction counter)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept the bundle this cycle
opcode5  input  5  instruction bits [6:2]; bits [1:0] are always emitted as 2'b11
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R format only)
imm  input  32  full-width immediate value (byte offset for B/J)
out_valid  output  1  out_inst valid
out_ready  input  1  consumer accepts out_inst
out_inst  output  32  encoded instruction
out_fmt  output  6  one-hot {r,i,s,b,u,j}, MSB = r
out_err  output  1  immediate not encodable (IMM_CHECK_EN only)
out_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Reset (clk edge with rst=1): both stage valids = 0, out_valid = 0, out_inst = 0, out_fmt = 0, out_err = 0, out_count = 0; in_ready = 1 in the first cycle after reset. Reset mid-transfer discards in-flight bundles with no output.
- Format decode from opcode5:
  - j = 11011
  - b = 11000
  - s = 01000
  - r = 01100
  - u = 01101 or 00101
  - i = none of the above
- Encoding, with opc = {opcode5, 2'b11}:
  - R: {funct7, rs2, rs1, funct3, rd, opc}
  - I: {imm[11:0], rs1, funct3, rd, opc}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}
  - U: {imm[31:12], rd, opc}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}
  - Fields unused by a format are ignored.
- Stage 1 (s1): registers the raw bundle and the decoded format.
- Stage 2 (s2): registers out_inst, out_fmt and out_err; out_valid = s2_valid.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = s1_valid & s2_adv
  - in_ready = !s1_valid | s2_adv
  - Input accepted when in_valid & in_ready.
- Latency: a bundle accepted at edge N shows out_valid=1 after edge N+1, if unstalled.
- Throughput: one bundle per cycle when out_ready is held 1.
- Stall rules:
  - out_valid=1 & out_ready=0: out_inst, out_fmt and out_err hold stable; out_valid must not drop.
  - With both stages full and stalled, in_ready=0.
- Simultaneous accept and emit in one cycle is legal; no bubble is inserted.
- out_count increments on each out_valid & out_ready, wraps from 2^CNT_W-1 to 0, and is unaffected by out_err.
- in_valid=0 cycles insert bubbles; an s1 bubble still advances.

Optional Feature:
Macro IMM_CHECK_EN.
- Defined: out_err=1 for the word when imm is not encodable; the instruction is still emitted with truncated bits. Not encodable means:
  - I/S: imm is not the sign-extension of imm[11:0]
  - B: imm is not the sign-extension of imm[12:0], or imm[0]=1
  - J: imm is not the sign-extension of imm[20:0], or imm[0]=1
  - U: imm[11:0] != 0
  - R: never
- Not defined: out_err tied to 0; silent truncation.

Test Plan:
1. After reset, opcode5=00100, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> out_inst=0x00500093, out_fmt=010000, latency 2 cycles, out_count=1.
2. Back-to-back, one per cycle:
   - add x3,x1,x2 (opcode5=01100, funct7=0) -> 0x002081B3
   - sw x2,8(x1) (opcode5=01000, funct3=010) -> 0x0020A423
   - lui x5 (opcode5=01101, imm=0x12345000) -> 0x123452B7
   - Expect 3 consecutive out_valid cycles and out_count=3.
3. beq x1,x2 (opcode5=11000, imm=0xFFFFFFFC) -> 0xFE208EE3; jal x1 (opcode5=11011, imm=8) -> 0x008000EF.
4. Backpressure:
   - out_ready=0 for 5 cycles while driving 3 bundles -> in_ready=0 once 2 bundles are held; out_inst stays stable.
   - Release out_ready -> exact in-order delivery, no loss or duplication.
5. With IMM_CHECK_EN:
   - I with imm=0x800 -> out_err=1
   - B with imm=6 -> out_err=0
   - J with imm=3 -> out_err=1
   - U with imm=0x1000 -> out_err=0
   - Without the macro, all give out_err=0.
6. Assert rst with both stages full -> next cycle out_valid=0, out_count=0, in_ready=1; no stale word appears. Also: CNT_W=4 with 17 handshakes -> out_count=1.
